map_controller: RTL and testbench
=================================

Name: map_controller

Overview:
- Owns the tile map for the display: 20x15 tiles, 3-bit code per tile.
- Serves the pixel renderer a registered tile-code lookup every cycle.
- Accepts robot move commands over a valid/ready handshake and applies each move during vertical blanking so a frame never shows a half-updated map.
- Reports the robot position and the outcome of each move to the game logic.

Parameters:
MAP_COLS, 20, tile columns (640/32)
MAP_ROWS, 15, tile rows (480/32)
START_COL, 0, robot column after reset
START_ROW, 9, robot row after reset

Ports:
clock_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
vblank_tick  in  1  one-cycle pulse at the start of vertical blanking
rd_col  in  5  renderer tile column (pix_x/32)
rd_row  in  4  renderer tile row (pix_y/32)
rd_code  out  3  tile code at (rd_col, rd_row), 1-cycle latency
cmd_valid  in  1  move request valid
cmd_dir  in  2  direction: 0 N (row-1), 1 E (col+1), 2 S (row+1), 3 W (col-1)
cmd_ready  out  1  high only in IDLE
move_done  out  1  one-cycle pulse when a command finishes
move_ok  out  1  valid with move_done; 1 = robot moved
robot_col  out  5  current robot column
robot_row  out  4  current robot row

Behaviour:
- Tile codes: 0 empty, 1 block, 2 robot, 3..7 reserved. Reserved codes are treated as blocking.
- Reset, and reset at any point mid-operation:
  - Map reloads the level constant in one cycle.
  - State returns to IDLE; cmd_ready=1.
  - robot_col/robot_row = START_COL/START_ROW.
  - move_done=0, move_ok=0, rd_code=0.
- Read port:
  - rd_code is registered from (rd_col, rd_row) every cycle in every state.
  - Coordinates with rd_col>=MAP_COLS or rd_row>=MAP_ROWS return 0.
  - A read of a cell being written in the same cycle returns the old value.
- Handshake:
  - A command is accepted when cmd_valid&&cmd_ready; cmd_dir is latched on acceptance.
  - While not ready, cmd_valid and cmd_dir are ignored. The requester holds the command.
- FSM:
  - IDLE: accept command -> WAIT_VBL. A vblank_tick in IDLE is ignored.
  - WAIT_VBL: wait for vblank_tick. A tick in the acceptance cycle itself does not count; the next tick is used.
  - CHECK: compute the target cell.
    - Out of bounds (col 0 going W, col MAP_COLS-1 going E, row 0 going N, row MAP_ROWS-1 going S) -> DONE with ok=0.
    - Target code !=0 -> DONE with ok=0.
    - Otherwise -> CLEAR.
  - CLEAR: write 0 to the old robot cell -> SET.
  - SET: write 2 to the target cell; update robot_col/robot_row -> DONE with ok=1.
  - DONE: move_done=1, move_ok=result -> IDLE.
- Latency for a tick in cycle V:
  - Success: CHECK V+1, CLEAR V+2, SET V+3, move_done V+4, cmd_ready=1 at V+5.
  - Blocked: move_done V+2, cmd_ready=1 at V+3.
- Position arithmetic:
  - Unsigned; the bounds check is done before any increment or decrement, so there is never wrap-around.
  - robot_col/robot_row change only in SET.
- Single write port; at most one map write per cycle.

Decomposition:
- Shared package/include map_defs:
  - Tile code constants (EMPTY=0, BLOCK=1, ROBOT=2).
  - Direction codes.
  - MAP_COLS/MAP_ROWS.
  - The level init table: 15 rows x 60 bits, column 0 in the MSBs.
  - Shared with the renderer.
- Sub-module map_tile_ram:
  - MAP_COLS*MAP_ROWS x 3 register array.
  - One registered read port and one write port, with read-before-write.
  - Synchronous reload from map_defs level on reset.
- Inside map_controller: FSM and position registers.

Test Plan:
- Reset: robot_col=0, robot_row=9, cmd_ready=1. rd (0,9)->2 and rd (0,8)->1 one cycle later. rd (25,3)->0.
- cmd E accepted: cmd_ready=0 until vblank_tick. Tick at V -> move_done=1, move_ok=1 at V+4. Robot at (1,9); rd (0,9)=0, rd (1,9)=2.
- cmd N from (0,9), target block (0,8)=1: move_done=1, move_ok=0 at V+2. Map and position unchanged.
- cmd W at column 0: move_ok=0, no write. Separately, drive robot to row 14, cmd S -> move_ok=0, robot_row stays 14.
- vblank_tick in the same cycle as acceptance: no progress; completion follows the next tick only. Also: cmd_valid held during busy -> exactly one move per accepted command.
- Assert reset in CLEAR state: next cycle the map is restored to the level, robot at (0,9), IDLE, no move_done pulse.

Source files
------------

// File: rtl/map_defs_pkg.sv
// Shared tile-map definitions: geometry, tile codes, directions and the level
// layout used by both the map controller and the pixel renderer.
package map_defs_pkg;

    localparam int unsigned MAP_COLS  = 20;
    localparam int unsigned MAP_ROWS  = 15;
    localparam int unsigned COL_W     = 5;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned CODE_W    = 3;
    localparam int unsigned LEVEL_W   = MAP_COLS * CODE_W;
    localparam int unsigned MAP_CELLS = MAP_COLS * MAP_ROWS;
    localparam int unsigned ADDR_W    = $clog2(MAP_CELLS);

    localparam logic [CODE_W-1:0] TILE_EMPTY = CODE_W'(0);
    localparam logic [CODE_W-1:0] TILE_BLOCK = CODE_W'(1);
    localparam logic [CODE_W-1:0] TILE_ROBOT = CODE_W'(2);

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_E = 2'd1,
        DIR_S = 2'd2,
        DIR_W = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_VBL,
        ST_CHECK,
        ST_CLEAR,
        ST_SET,
        ST_DONE
    } state_e;

    // One row per entry, 3 bits per tile, column 0 in the MSBs.
    localparam logic [LEVEL_W-1:0] LEVEL [MAP_ROWS] = '{
        60'h000000000000000,   // row 0
        60'h000000000000000,   // row 1
        60'h000000000000000,   // row 2
        60'h000000000000001,   // row 3: block at col 19
        60'h000000000000000,   // row 4
        60'h000000000000000,   // row 5
        60'h000000000000000,   // row 6
        60'h000000000000000,   // row 7
        60'h200040000000000,   // row 8: blocks at col 0 and col 5
        60'h400000000000000,   // row 9: robot start at col 0
        60'h000000000000000,   // row 10
        60'h000000000000000,   // row 11
        60'h000000008000000,   // row 12: block at col 10
        60'h000000000000005,   // row 13: reserved code 5 at col 19
        60'h000000000000000    // row 14
    };

    function automatic logic [CODE_W-1:0] level_code(input logic [ROW_W-1:0] row,
                                                     input logic [COL_W-1:0] col);
        logic [LEVEL_W-1:0] bits;
        bits = LEVEL[row] >> (CODE_W * (MAP_COLS - 1 - 32'(col)));
        return bits[CODE_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [COL_W-1:0] col,
                                                    input logic [ROW_W-1:0] row);
        return ADDR_W'(row) * ADDR_W'(MAP_COLS) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/map_tile_ram.sv
// Tile-code storage: registered renderer read port, combinational probe for the
// move checker, one write port, and a one-cycle reload of the level on reset.
module map_tile_ram
    import map_defs_pkg::*;
(
    input  logic              clock_50,
    input  logic              reset,
    input  logic [COL_W-1:0]  rd_col,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [CODE_W-1:0] rd_code,
    input  logic [COL_W-1:0]  chk_col,
    input  logic [ROW_W-1:0]  chk_row,
    output logic [CODE_W-1:0] chk_code_c,
    input  logic              wr_en,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [ROW_W-1:0]  wr_row,
    input  logic [CODE_W-1:0] wr_code
);

    logic [CODE_W-1:0] mem [MAP_CELLS];
    logic              rd_in_range_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [ADDR_W-1:0] chk_addr_c;

    always_comb begin
        rd_in_range_c = (rd_col < COL_W'(MAP_COLS)) && (rd_row < ROW_W'(MAP_ROWS));
        rd_addr_c     = cell_addr(rd_col, rd_row);
        wr_addr_c     = cell_addr(wr_col, wr_row);
        chk_addr_c    = cell_addr(chk_col, chk_row);
        chk_code_c    = mem[chk_addr_c];
    end

    // Per-cell registers so reset can reload the whole level in a single cycle.
    for (genvar a = 0; a < MAP_CELLS; a++) begin : g_cell
        always_ff @(posedge clock_50) begin
            if (reset) begin
                mem[a] <= level_code(ROW_W'(a / MAP_COLS), COL_W'(a % MAP_COLS));
            end else if (wr_en && (wr_addr_c == ADDR_W'(a))) begin
                mem[a] <= wr_code;
            end
        end
    end

    // Nonblocking read returns the pre-write value on a same-cycle collision.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            rd_code <= TILE_EMPTY;
        end else if (rd_in_range_c) begin
            rd_code <= mem[rd_addr_c];
        end else begin
            rd_code <= TILE_EMPTY;
        end
    end

endmodule

// File: rtl/map_controller.sv
// Tile-map owner: serves renderer lookups and applies robot moves during
// vertical blanking so a frame never shows a half-updated map.
module map_controller
    import map_defs_pkg::*;
#(
    parameter int unsigned START_COL = 0,
    parameter int unsigned START_ROW = 9
) (
    input  logic              clock_50,
    input  logic              reset,
    input  logic              vblank_tick,
    input  logic [COL_W-1:0]  rd_col,
    input  logic [ROW_W-1:0]  rd_row,
    output logic [CODE_W-1:0] rd_code,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_dir,
    output logic              cmd_ready,
    output logic              move_done,
    output logic              move_ok,
    output logic [COL_W-1:0]  robot_col,
    output logic [ROW_W-1:0]  robot_row
);

    state_e            state;
    state_e            state_d;
    dir_e              dir_q;
    logic              accept_c;
    logic [COL_W-1:0]  tgt_col_c;
    logic [ROW_W-1:0]  tgt_row_c;
    logic              tgt_oob_c;
    logic [CODE_W-1:0] tgt_code_c;
    logic              wr_en_c;
    logic [COL_W-1:0]  wr_col_c;
    logic [ROW_W-1:0]  wr_row_c;
    logic [CODE_W-1:0] wr_code_c;

    map_tile_ram u_ram (
        .clock_50   (clock_50),
        .reset      (reset),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_code    (rd_code),
        .chk_col    (tgt_col_c),
        .chk_row    (tgt_row_c),
        .chk_code_c (tgt_code_c),
        .wr_en      (wr_en_c),
        .wr_col     (wr_col_c),
        .wr_row     (wr_row_c),
        .wr_code    (wr_code_c)
    );

    // Edge test precedes the step, so coordinates never wrap.
    always_comb begin
        tgt_col_c = robot_col;
        tgt_row_c = robot_row;
        tgt_oob_c = 1'b0;
        case (dir_q)
            DIR_N: begin
                if (robot_row == '0) tgt_oob_c = 1'b1;
                else                 tgt_row_c = robot_row - ROW_W'(1);
            end
            DIR_E: begin
                if (robot_col == COL_W'(MAP_COLS - 1)) tgt_oob_c = 1'b1;
                else                                   tgt_col_c = robot_col + COL_W'(1);
            end
            DIR_S: begin
                if (robot_row == ROW_W'(MAP_ROWS - 1)) tgt_oob_c = 1'b1;
                else                                   tgt_row_c = robot_row + ROW_W'(1);
            end
            DIR_W: begin
                if (robot_col == '0) tgt_oob_c = 1'b1;
                else                 tgt_col_c = robot_col - COL_W'(1);
            end
            default: tgt_oob_c = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state;
        accept_c  = 1'b0;
        wr_en_c   = 1'b0;
        wr_col_c  = robot_col;
        wr_row_c  = robot_row;
        wr_code_c = TILE_EMPTY;
        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept_c = 1'b1;
                    state_d  = ST_WAIT_VBL;
                end
            end
            ST_WAIT_VBL: begin
                if (vblank_tick) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // Reserved codes are nonzero, so they block like a wall.
                if (tgt_oob_c || (tgt_code_c != TILE_EMPTY)) state_d = ST_DONE;
                else                                         state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                wr_en_c = 1'b1;
                state_d = ST_SET;
            end
            ST_SET: begin
                wr_en_c   = 1'b1;
                wr_col_c  = tgt_col_c;
                wr_row_c  = tgt_row_c;
                wr_code_c = TILE_ROBOT;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake and result outputs are registered from the next state.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir_q     <= DIR_N;
            robot_col <= COL_W'(START_COL);
            robot_row <= ROW_W'(START_ROW);
            cmd_ready <= 1'b1;
            move_done <= 1'b0;
            move_ok   <= 1'b0;
        end else begin
            state     <= state_d;
            if (accept_c) dir_q <= dir_e'(cmd_dir);
            if (state == ST_SET) begin
                robot_col <= tgt_col_c;
                robot_row <= tgt_row_c;
            end
            cmd_ready <= (state_d == ST_IDLE);
            move_done <= (state_d == ST_DONE);
            move_ok   <= (state_d == ST_DONE) && (state == ST_SET);
        end
    end

endmodule

// File: tb/tb_map_controller.sv
// Scoreboard bench for map_controller: random and directed moves checked
// against a coordinate-level model of the map and robot.
module tb_map_controller;
    import map_defs_pkg::*;

    logic       clock_50 = 1'b0;
    logic       reset;
    logic       vblank_tick;
    logic [4:0] rd_col;
    logic [3:0] rd_row;
    logic [2:0] rd_code;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;
    logic       move_done;
    logic       move_ok;
    logic [4:0] robot_col;
    logic [3:0] robot_row;

    always #10 clock_50 = ~clock_50;

    map_controller dut (
        .clock_50    (clock_50),
        .reset       (reset),
        .vblank_tick (vblank_tick),
        .rd_col      (rd_col),
        .rd_row      (rd_row),
        .rd_code     (rd_code),
        .cmd_valid   (cmd_valid),
        .cmd_dir     (cmd_dir),
        .cmd_ready   (cmd_ready),
        .move_done   (move_done),
        .move_ok     (move_ok),
        .robot_col   (robot_col),
        .robot_row   (robot_row)
    );

    typedef struct {
        bit ok;
        int col;
        int row;
        int lat;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   checks   = 0;
    int   passes   = 0;
    int   cyc      = 0;
    int   tick_cyc = -1000;
    int   mdl [int];
    int   rc;
    int   rr;

    always @(posedge clock_50) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic void model_reset();
        for (int r = 0; r < int'(MAP_ROWS); r++)
            for (int c = 0; c < int'(MAP_COLS); c++)
                mdl[r*100 + c] = int'(3'(LEVEL[4'(r)] >> (3 * (19 - c))));
        rc = 0;
        rr = 9;
    endfunction

    function automatic int model_rd(input int c, input int r);
        if (c >= int'(MAP_COLS) || r >= int'(MAP_ROWS)) return 0;
        return mdl[r*100 + c];
    endfunction

    function automatic void model_move(input int d, output bit ok);
        int tc;
        int tr;
        tc = rc;
        tr = rr;
        case (d)
            0:       tr = tr - 1;
            1:       tc = tc + 1;
            2:       tr = tr + 1;
            default: tc = tc - 1;
        endcase
        ok = (tc >= 0) && (tc < int'(MAP_COLS)) && (tr >= 0) && (tr < int'(MAP_ROWS));
        if (ok) ok = (mdl[tr*100 + tc] == 0);
        if (ok) begin
            mdl[rr*100 + rc] = 0;
            mdl[tr*100 + tc] = 2;
            rc = tc;
            rr = tr;
        end
    endfunction

    // Monitor: every move_done pulse must match the oldest expected outcome.
    always @(negedge clock_50) begin
        if (move_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_move_done", int'(move_done), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("move_ok", int'(move_ok), int'(mon_e.ok));
                chk("done_col", int'(robot_col), mon_e.col);
                chk("done_row", int'(robot_row), mon_e.row);
                chk("done_latency", cyc - tick_cyc, mon_e.lat);
            end
        end
    end

    task automatic check_rd(input int c, input int r);
        rd_col = 5'(c);
        rd_row = 4'(r);
        @(negedge clock_50);
        chk($sformatf("rd(%0d,%0d)", c, r), int'(rd_code), model_rd(c, r));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock_50);
        reset = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic do_move(input int d, input bit hold, input bit tick_acc, input int gap);
        bit   ok;
        int   n;
        int   pc;
        exp_t e;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clock_50);
            n++;
        end
        chk("ready_before_cmd", int'(cmd_ready), 1);
        pc          = rc;
        cmd_valid   = 1'b1;
        cmd_dir     = 2'(d);
        vblank_tick = tick_acc;
        model_move(d, ok);
        e.ok  = ok;
        e.col = rc;
        e.row = rr;
        e.lat = ok ? 4 : 2;
        sb.push_back(e);
        @(negedge clock_50);
        vblank_tick = 1'b0;
        if (hold) cmd_dir = 2'($urandom_range(0, 3));
        else      cmd_valid = 1'b0;
        chk("ready_low_after_accept", int'(cmd_ready), 0);
        if (tick_acc) begin
            repeat (4) @(negedge clock_50);
            chk("tick_at_accept_ignored", int'(cmd_ready), 0);
            chk("tick_at_accept_col", int'(robot_col), pc);
        end
        repeat (gap) @(negedge clock_50);
        vblank_tick = 1'b1;
        tick_cyc    = cyc;
        @(negedge clock_50);
        vblank_tick = 1'b0;
        n = 0;
        while (!move_done && n < 8) begin
            @(negedge clock_50);
            n++;
        end
        chk("move_done_seen", int'(move_done), 1);
        cmd_valid = 1'b0;
        @(negedge clock_50);
        chk("ready_after_done", int'(cmd_ready), 1);
        if (hold) begin
            repeat (3) @(negedge clock_50);
            chk("held_valid_one_move_col", int'(robot_col), rc);
            chk("held_valid_one_move_row", int'(robot_row), rr);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int d;
        reset       = 1'b1;
        vblank_tick = 1'b0;
        cmd_valid   = 1'b0;
        cmd_dir     = 2'd0;
        rd_col      = 5'd0;
        rd_row      = 4'd9;
        repeat (2) @(negedge clock_50);
        chk("rd_code_in_reset", int'(rd_code), 0);
        chk("reset_ready", int'(cmd_ready), 1);
        chk("reset_col", int'(robot_col), 0);
        chk("reset_row", int'(robot_row), 9);
        chk("reset_done", int'(move_done), 0);
        reset = 1'b0;
        model_reset();

        check_rd(0, 9);
        check_rd(0, 8);
        check_rd(25, 3);
        check_rd(4, 15);
        check_rd(19, 13);

        // Blocked by wall tile, then by the left edge.
        do_move(0, 0, 0, 2);
        check_rd(0, 8);
        check_rd(0, 9);
        do_move(3, 0, 0, 1);
        check_rd(0, 9);
        // Successful step east.
        do_move(1, 0, 0, 0);
        check_rd(0, 9);
        check_rd(1, 9);
        // Down to the bottom row, exercising tick-at-accept and held valid.
        do_move(2, 0, 1, 1);
        do_move(2, 1, 0, 3);
        do_move(2, 0, 0, 0);
        do_move(2, 1, 1, 2);
        do_move(2, 0, 0, 0);
        do_move(2, 0, 0, 1);
        chk("bottom_row_kept", int'(robot_row), 14);
        // Across to the right edge, then edge and reserved-code blocks.
        for (int i = 0; i < 18; i++) do_move(1, 0, 0, i % 3);
        do_move(1, 0, 0, 0);
        do_move(0, 0, 0, 1);
        check_rd(19, 14);
        check_rd(19, 13);

        for (int i = 0; i < 40; i++) begin
            d = int'($urandom_range(0, 3));
            do_move(d, bit'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                    int'($urandom_range(0, 4)));
            check_rd(int'($urandom_range(0, 21)), int'($urandom_range(0, 15)));
            check_rd(rc, rr);
        end

        // Reset restores the whole level after moves have edited it.
        do_reset();
        for (int r = 0; r < int'(MAP_ROWS); r++)
            for (int c = 0; c < int'(MAP_COLS); c++)
                check_rd(c, r);

        // Reset asserted while the FSM is in CLEAR.
        cmd_valid = 1'b1;
        cmd_dir   = 2'd1;
        @(negedge clock_50);
        cmd_valid = 1'b0;
        @(negedge clock_50);
        vblank_tick = 1'b1;
        @(negedge clock_50);
        vblank_tick = 1'b0;
        @(negedge clock_50);
        reset = 1'b1;
        @(negedge clock_50);
        reset = 1'b0;
        chk("clear_reset_ready", int'(cmd_ready), 1);
        chk("clear_reset_col", int'(robot_col), 0);
        chk("clear_reset_row", int'(robot_row), 9);
        chk("clear_reset_done", int'(move_done), 0);
        chk("clear_reset_rd", int'(rd_code), 0);
        repeat (6) @(negedge clock_50);
        check_rd(0, 9);
        check_rd(1, 9);
        do_move(1, 0, 0, 1);
        check_rd(0, 9);
        check_rd(1, 9);
        repeat (3) @(negedge clock_50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
